// File: rtl/gpsdo_pkg.sv
// Shared types and constants for the GPSDO 1PPS phase detector.
package gpsdo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LOCAL,
    WAIT_GPS
  } pps_state_e;

  // Result sign when the GPS edge arrives first.
  localparam bit GPS_LEAD_POSITIVE = 1'b1;

  localparam int unsigned DEFAULT_TIMEOUT = 50000000;

endpackage

// File: rtl/pps_edge_sync.sv
// Multi-flop synchroniser for an asynchronous PPS input followed by a rising-edge strobe.
module pps_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic CLK_SYS,
  input  logic CLK_RST,
  input  logic async_in,
  output logic strobe
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge CLK_SYS or posedge CLK_RST) begin
    if (CLK_RST) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign strobe = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/pps_phase_detector.sv
// Measures the signed GPS-to-local 1PPS interval in CLK_SYS cycles; results, event pulses
// and the lock indicator are all registered, one cycle after the triggering strobe.
module pps_phase_detector
  import gpsdo_pkg::*;
#(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned TIMEOUT      = DEFAULT_TIMEOUT,
  parameter int unsigned LOCK_THRESH  = 5,
  parameter int unsigned LOCK_COUNT   = 4,
  parameter int unsigned UNLOCK_COUNT = 2
) (
  input  logic                    CLK_SYS,
  input  logic                    CLK_RST,
  input  logic                    _1PPS_GPS,
  input  logic                    _1PPS_Local,
  output logic signed [CNT_W-1:0] Phase_Err,
  output logic                    Phase_Valid,
  input  logic                    Phase_Ready,
  output logic                    Overrun,
  output logic                    Timeout_Pulse,
  output logic                    Missed_Pulse,
  output logic                    LED_Lock
);

  localparam int unsigned GW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned BW = $clog2(UNLOCK_COUNT + 1);

  logic gps_stb, local_stb;

  pps_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_gps (
    .CLK_SYS  (CLK_SYS),
    .CLK_RST  (CLK_RST),
    .async_in (_1PPS_GPS),
    .strobe   (gps_stb)
  );

  pps_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_local (
    .CLK_SYS  (CLK_SYS),
    .CLK_RST  (CLK_RST),
    .async_in (_1PPS_Local),
    .strobe   (local_stb)
  );

  pps_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   res_ev, timeout_ev, missed_ev, res_gps_lead;
  logic [CNT_W-1:0]       res_mag;
  logic signed [CNT_W-1:0] res_err;
  logic                   in_window;

  always_ff @(posedge CLK_SYS or posedge CLK_RST) begin
    if (CLK_RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    res_ev       = 1'b0;
    res_mag      = '0;
    res_gps_lead = 1'b0;
    timeout_ev   = 1'b0;
    missed_ev    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (gps_stb && local_stb) begin
          res_ev = 1'b1;
        end else if (gps_stb) begin
          state_d = WAIT_LOCAL;
        end else if (local_stb) begin
          state_d = WAIT_GPS;
        end
      end
      WAIT_LOCAL, WAIT_GPS: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Partner wins over a repeated leading edge; a repeat wins over timeout.
        if ((state_q == WAIT_LOCAL) ? local_stb : gps_stb) begin
          res_ev       = 1'b1;
          res_mag      = cnt_q + CNT_W'(1);
          res_gps_lead = (state_q == WAIT_LOCAL);
          state_d      = IDLE;
          cnt_d        = '0;
        end else if ((state_q == WAIT_LOCAL) ? gps_stb : local_stb) begin
          missed_ev = 1'b1;
          cnt_d     = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          timeout_ev = 1'b1;
          state_d    = IDLE;
          cnt_d      = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign res_err   = (res_gps_lead == GPS_LEAD_POSITIVE) ? res_mag : -res_mag;
  assign in_window = (res_mag <= CNT_W'(LOCK_THRESH));

  logic signed [CNT_W-1:0] err_q;
  logic                    valid_q, overrun_q, timeout_q, missed_q, lock_q;
  logic [GW-1:0]           good_q, good_next;
  logic [BW-1:0]           bad_q, bad_next;

  assign good_next = (good_q == GW'(LOCK_COUNT))   ? good_q : good_q + GW'(1);
  assign bad_next  = (bad_q  == BW'(UNLOCK_COUNT)) ? bad_q  : bad_q  + BW'(1);

  always_ff @(posedge CLK_SYS or posedge CLK_RST) begin
    if (CLK_RST) begin
      err_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
      missed_q  <= 1'b0;
      lock_q    <= 1'b0;
      good_q    <= '0;
      bad_q     <= '0;
    end else begin
      timeout_q <= timeout_ev;
      missed_q  <= missed_ev;
      if (res_ev) begin
        err_q   <= res_err;
        valid_q <= 1'b1;
        if (valid_q && !Phase_Ready) overrun_q <= 1'b1;
      end else if (valid_q && Phase_Ready) begin
        valid_q <= 1'b0;
      end
      if (timeout_ev) begin
        good_q <= '0;
        bad_q  <= '0;
        lock_q <= 1'b0;
      end else if (res_ev) begin
        if (in_window) begin
          good_q <= good_next;
          bad_q  <= '0;
          if (good_next == GW'(LOCK_COUNT)) lock_q <= 1'b1;
        end else begin
          bad_q  <= bad_next;
          good_q <= '0;
          if (bad_next == BW'(UNLOCK_COUNT)) lock_q <= 1'b0;
        end
      end
    end
  end

  assign Phase_Err     = err_q;
  assign Phase_Valid   = valid_q;
  assign Overrun       = overrun_q;
  assign Timeout_Pulse = timeout_q;
  assign Missed_Pulse  = missed_q;
  assign LED_Lock      = lock_q;

endmodule

// File: tb/tb_pps_phase_detector.sv
// Scoreboard bench for pps_phase_detector: directed PPS edge patterns with hand-computed results.
module tb_pps_phase_detector;

  localparam int unsigned CNT_W = 32;
  localparam int unsigned SYNC  = 2;
  localparam int unsigned TMO   = 1000;

  logic                    clk, rst, gps, loc, ready;
  logic signed [CNT_W-1:0] phase_err;
  logic                    phase_valid, overrun, timeout_pulse, missed_pulse, led_lock;

  pps_phase_detector #(
    .CNT_W        (CNT_W),
    .SYNC_STAGES  (SYNC),
    .TIMEOUT      (TMO),
    .LOCK_THRESH  (5),
    .LOCK_COUNT   (4),
    .UNLOCK_COUNT (2)
  ) dut (
    .CLK_SYS       (clk),
    .CLK_RST       (rst),
    ._1PPS_GPS     (gps),
    ._1PPS_Local   (loc),
    .Phase_Err     (phase_err),
    .Phase_Valid   (phase_valid),
    .Phase_Ready   (ready),
    .Overrun       (overrun),
    .Timeout_Pulse (timeout_pulse),
    .Missed_Pulse  (missed_pulse),
    .LED_Lock      (led_lock)
  );

  typedef struct {
    int val;
    int cyc;  // expected cycle of Phase_Valid rising, -1 = don't care
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   to_cnt = 0, to_cyc = -1, ms_cnt = 0, rise_cyc = -1;
  logic prev_valid = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (timeout_pulse) begin to_cnt++; to_cyc = cyc; end
      if (missed_pulse) ms_cnt++;
      if (phase_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = phase_valid;
      if (phase_valid && ready) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_result got=%0d expected=none", phase_err);
        end else begin
          e = q.pop_front();
          if (phase_err != e.val || (e.cyc >= 0 && rise_cyc != e.cyc)) begin
            bad++;
            $display("FAIL result got=%0d@%0d expected=%0d@%0d", phase_err, rise_cyc, e.val,
                     e.cyc);
          end
        end
      end
    end
  end

  function automatic logic lvl(input int n, input int t);
    return t >= 0 && n >= t && n < t + 2;
  endfunction

  // Drive 2-cycle PPS pulses at the given cycle offsets (-1 = none); optionally expect a result.
  task automatic run_edges(input int g0, input int g1, input int l0, input int span,
                           input bit push, input int val, input int part_at, output int start);
    start = 0;
    for (int n = 0; n < span; n++) begin
      @(posedge clk);
      #1;
      if (n == 0) begin
        start = cyc;
        if (push) q.push_back('{val, (part_at < 0) ? -1 : cyc + part_at + int'(SYNC) + 1});
      end
      gps = lvl(n, g0) | lvl(n, g1);
      loc = lvl(n, l0);
    end
    gps = 1'b0;
    loc = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_err"}, phase_err, 0);
    chk({tag, "_valid"}, phase_valid, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_timeout"}, timeout_pulse, 0);
    chk({tag, "_missed"}, missed_pulse, 0);
    chk({tag, "_lock"}, led_lock, 0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, base;
    rst = 1'b1; gps = 1'b0; loc = 1'b0; ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    repeat (3) @(posedge clk);

    run_edges(0, -1, 100, 110, 1'b1, 100, 100, st);
    chk("gps_lead_overrun", overrun, 0);
    chk("gps_lead_lock", led_lock, 0);
    run_edges(37, -1, 0, 47, 1'b1, -37, 37, st);
    chk("local_lead_lock", led_lock, 0);

    for (int i = 0; i < 4; i++) begin
      run_edges(0, -1, 0, 10, 1'b1, 0, 0, st);
      chk("lock_build", led_lock, (i == 3) ? 1 : 0);
    end
    for (int i = 0; i < 2; i++) begin
      run_edges(0, -1, 20, 30, 1'b1, 20, 20, st);
      chk("lock_drop", led_lock, (i == 1) ? 0 : 1);
    end
    for (int i = 0; i < 4; i++) run_edges(0, -1, 0, 10, 1'b1, 0, 0, st);
    chk("relock", led_lock, 1);

    base = to_cnt;
    run_edges(0, -1, -1, 5, 1'b0, 0, 0, st);
    for (int i = 0; i < 1200 && to_cnt == base; i++) @(posedge clk);
    #1;
    chk("timeout_seen", to_cnt - base, 1);
    chk("timeout_cycle", to_cyc, st + int'(TMO) + int'(SYNC) + 1);
    chk("timeout_lock", led_lock, 0);
    chk("timeout_no_valid", phase_valid, 0);
    @(posedge clk);
    #1;
    chk("timeout_one_cycle", timeout_pulse, 0);

    ready = 1'b0;
    run_edges(0, -1, 10, 20, 1'b0, 0, 0, st);
    run_edges(0, -1, 12, 22, 1'b1, 12, -1, st);
    chk("overrun_flag", overrun, 1);
    chk("overrun_err", phase_err, 12);
    chk("overrun_valid", phase_valid, 1);
    @(posedge clk);
    #1;
    ready = 1'b1;
    @(posedge clk);
    #1;
    chk("accept_drop", phase_valid, 0);

    base = ms_cnt;
    run_edges(0, 200, 250, 260, 1'b1, 50, 250, st);
    chk("missed_count", ms_cnt - base, 1);

    run_edges(0, -1, -1, 30, 1'b0, 0, 0, st);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run_edges(-1, -1, 0, 40, 1'b0, 0, 0, st);
    chk("post_reset_no_valid", phase_valid, 0);
    chk("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
